// File: rtl/adder_share_arb_pkg.sv
// Shared constants and the round-robin pick helper for the adder-sharing arbiter.
// Segment boundaries of the approximate adder live here so the datapath and arbiter agree.
package adder_share_pkg;

    localparam int DATA_W     = 16;
    localparam int APX_LO_W   = 8;
    localparam int APX_HI_LSB = 4;
    localparam int MAX_REQ    = 8;
    localparam int PTR_W      = 3;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // First valid index at or after ptr, searching cyclically over nreq requesters.
    function automatic rr_pick_t f_rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [PTR_W-1:0]   ptr,
                                           input int                 nreq);
        rr_pick_t r;
        int       k;
        r = '0;
        for (int off = 0; off < MAX_REQ; off++) begin
            k = int'(ptr) + off;
            if (k >= nreq) k = k - nreq;
            if (off < nreq && !r.found && valid[k]) begin
                r.found = 1'b1;
                r.idx   = PTR_W'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_share_arb_if.sv
// Request/response bundle between requesters, the shared-adder arbiter and its consumer.
interface adder_share_arb_if
    import adder_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [DATA_W*NREQ-1:0] req_a;
    logic [DATA_W*NREQ-1:0] req_b;
    logic [NREQ-1:0]        req_exact;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [DATA_W-1:0]      rsp_sum;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, req_exact, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_exact, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, busy
    );
endinterface

// File: rtl/adder_share_arb_ap_adder.sv
// Segmented approximate adder: exact low byte, upper sum from bits [15:4] with A[0] folded in
// as a cheap carry guess; the low/high segments never propagate carries into each other.
module adder_share_arb_ap_adder
    import adder_share_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);
    localparam int HI_W = DATA_W - APX_HI_LSB;

    logic [APX_LO_W:0] sl;
    logic [HI_W:0]     sh;
    logic              unused_bits;

    assign sl = {1'b0, a[APX_LO_W-1:0]} + {1'b0, b[APX_LO_W-1:0]};
    assign sh = {1'b0, a[DATA_W-1:APX_HI_LSB]} + {1'b0, b[DATA_W-1:APX_HI_LSB]}
              + (HI_W+1)'(a[0]);

    // Upper byte comes from SH[11:4]; the overlap bits and both carry-outs are dropped.
    assign sum = {sh[HI_W-1:APX_LO_W-APX_HI_LSB], sl[APX_LO_W-1:0]};

    assign unused_bits = ^{sl[APX_LO_W], sh[HI_W], sh[APX_LO_W-APX_HI_LSB-1:0]};
endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one approximate adder (plus an inline exact add) among NREQ
// requesters, with a single registered result stage and valid/ready on both sides.
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
)
(
    input logic             clk,
    input logic             rst_n,
    adder_share_arb_if.slave bus
);
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    ptr_nxt;
    logic [IDW-1:0]    id_sel;
    rr_pick_t          pick;
    logic              stage_free;
    logic              grant;
    logic              exact_sel;
    logic [NREQ-1:0]   ready;
    logic [DATA_W-1:0] a_sel, b_sel, ap_sum, ex_sum, sum_sel;

    logic              rsp_valid_q;
    logic [IDW-1:0]    rsp_id_q;
    logic [DATA_W-1:0] rsp_sum_q;

    assign stage_free = !rsp_valid_q || bus.rsp_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        pick      = f_rr_pick(MAX_REQ'(bus.req_valid), PTR_W'(ptr), NREQ);
        grant     = rst_n && stage_free && pick.found;
        ready     = '0;
        a_sel     = '0;
        b_sel     = '0;
        exact_sel = 1'b0;
        id_sel    = '0;
        ptr_nxt   = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == pick.idx) begin
                a_sel     = bus.req_a[i*DATA_W +: DATA_W];
                b_sel     = bus.req_b[i*DATA_W +: DATA_W];
                exact_sel = bus.req_exact[i];
                id_sel    = IDW'(i);
                ptr_nxt   = (i == NREQ - 1) ? '0 : IDW'(i + 1);
                ready[i]  = grant;
            end
        end
    end

    adder_share_arb_ap_adder i_ap_adder (
        .a   (a_sel),
        .b   (b_sel),
        .sum (ap_sum)
    );

    assign ex_sum  = a_sel + b_sel;
    assign sum_sel = exact_sel ? ex_sum : ap_sum;

    // A new grant overrides the drain, giving back-to-back results with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            ptr         <= '0;
        end else if (grant) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_sel;
            rsp_sum_q   <= sum_sel;
            ptr         <= ptr_nxt;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.busy      = rsp_valid_q || (|bus.req_valid);
endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench: per-requester drivers, expected results queued at issue time and
// popped by an independent response monitor.
module tb_adder_share_arb;
    import adder_share_pkg::*;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        exact;
    } op_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    sum;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    exp_t            exp_q[$];
    op_t             ops[NREQ][DEPTH];
    int              head[NREQ];
    int              tail[NREQ];
    logic [NREQ-1:0] hold;
    logic [NREQ-1:0] acc_s;
    logic [NREQ-1:0] prev_pend;

    adder_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    adder_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic ex, input logic [15:0] sum);
        exp_t e;
        ops[i][tail[i]] = '{a: a, b: b, exact: ex};
        tail[i]++;
        e.id  = IDW'(i);
        e.sum = sum;
        exp_q.push_back(e);
    endtask

    function automatic logic pending();
        logic p = 1'b0;
        for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) p = 1'b1;
        return p;
    endfunction

    task automatic wait_idle(input string name);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && hold == '0 && !pending() && !bus.rsp_valid) return;
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout actual=queued:%0d required=queued:0", name, exp_q.size());
    endtask

    // Requester drivers: hold operands until accepted, then present the next queued op.
    initial begin
        hold          = '0;
        acc_s         = '0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_exact = '0;
        for (int i = 0; i < NREQ; i++) begin head[i] = 0; tail[i] = 0; end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hold[i] && acc_s[i]) hold[i] = 1'b0;
                if (!hold[i] && head[i] != tail[i]) begin
                    bus.req_a[i*16 +: 16] = ops[i][head[i]].a;
                    bus.req_b[i*16 +: 16] = ops[i][head[i]].b;
                    bus.req_exact[i]      = ops[i][head[i]].exact;
                    head[i]++;
                    hold[i] = 1'b1;
                end
                bus.req_valid[i] = hold[i];
            end
        end
    end

    // Handshake sampler plus the rule that a pending request is never withdrawn.
    initial begin
        prev_pend = '0;
        forever begin
            @(negedge clk);
            if (rst_n && prev_pend != '0)
                check("req_withdrawn", bus.req_valid & prev_pend, prev_pend);
            acc_s     = bus.req_valid & bus.req_ready;
            prev_pend = rst_n ? (bus.req_valid & ~bus.req_ready) : '0;
        end
    end

    // Response monitor: every transferred result must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual=id:%0d sum:0x%0h required=none",
                             bus.rsp_id, bus.rsp_sum);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    check("rsp_sum", 32'(bus.rsp_sum), 32'(e.sum));
                end
            end
        end
    end

    initial begin
        int              order[5];
        logic [NREQ-1:0] exp_rdy;

        order = '{0, 1, 2, 3, 0};
        bus.rsp_ready = 1'b0;
        #12;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        check("reset_rsp_id", 32'(bus.rsp_id), 0);
        check("reset_rsp_sum", 32'(bus.rsp_sum), 0);
        check("reset_req_ready", 32'(bus.req_ready), 0);
        check("reset_busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;

        // Single approximate request: carry into bit 4 of the high segment is lost.
        @(negedge clk);
        issue(1, 16'h00F8, 16'h0008, 1'b0, 16'h0000);
        @(negedge clk);
        check("single_grant", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        check("single_latency", 32'(bus.rsp_valid), 1);
        wait_idle("single");
        check("idle_busy", 32'(bus.busy), 0);

        issue(1, 16'h00F8, 16'h0008, 1'b1, 16'h0100);
        wait_idle("single_exact");
        issue(2, 16'h00F1, 16'h0000, 1'b0, 16'h01F1);
        issue(2, 16'h00F1, 16'h0000, 1'b1, 16'h00F1);
        wait_idle("noise");
        issue(3, 16'h0003, 16'h0004, 1'b0, 16'h0007);
        wait_idle("to_ptr0");

        // All four requesters contend starting from ptr=0.
        issue(0, 16'h1234, 16'h0001, 1'b1, 16'h1235);
        issue(1, 16'h0003, 16'h0004, 1'b0, 16'h0007);
        issue(2, 16'h1000, 16'h2000, 1'b0, 16'h3000);
        issue(3, 16'hFFFF, 16'h0001, 1'b0, 16'h0000);
        issue(0, 16'h0F0F, 16'h00F0, 1'b1, 16'h0FFF);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            exp_rdy = NREQ'(1) << order[k];
            check("rr_grant", 32'(bus.req_ready), 32'(exp_rdy));
            @(negedge clk);
            check("rr_throughput", 32'(bus.rsp_valid), 1);
        end
        wait_idle("rr");

        // Back-pressure for three cycles, then drain and grant in the same cycle.
        issue(1, 16'h0100, 16'h0200, 1'b1, 16'h0300);
        issue(2, 16'h4321, 16'h1111, 1'b1, 16'h5432);
        @(negedge clk);
        check("bp_first_grant", 32'(bus.req_ready), 32'h2);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_busy", 32'(bus.busy), 1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_valid", 32'(bus.rsp_valid), 1);
            check("bp_id_stable", 32'(bus.rsp_id), 1);
            check("bp_sum_stable", 32'(bus.rsp_sum), 32'h0300);
            check("bp_no_ready", 32'(bus.req_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_grant_on_drain", 32'(bus.req_ready), 32'h4);
        @(negedge clk);
        check("bp_no_bubble", 32'(bus.rsp_valid), 1);
        check("bp_next_id", 32'(bus.rsp_id), 2);
        wait_idle("bp");

        // Grant 3 wraps ptr to 0; idle cycles must not move it.
        issue(3, 16'h00FF, 16'h0001, 1'b0, 16'h0100);
        wait_idle("wrap");
        repeat (3) @(negedge clk);
        issue(0, 16'h0010, 16'h0020, 1'b0, 16'h0030);
        issue(2, 16'h0A0A, 16'h0505, 1'b0, 16'h0F0F);
        @(negedge clk);
        check("wrap_idle_grant", 32'(bus.req_ready), 32'h1);
        wait_idle("wrap_idle");

        // Reset while a result is stalled: it must vanish at once and never reappear.
        bus.rsp_ready = 1'b0;
        issue(1, 16'h1111, 16'h2222, 1'b1, 16'h3333);
        @(negedge clk);
        check("rst_pre_grant", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        check("rst_pre_valid", 32'(bus.rsp_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(bus.rsp_valid), 0);
        check("rst_async_ready", 32'(bus.req_ready), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_stale", 32'(bus.rsp_valid), 0);
        end
        issue(2, 16'hFFFF, 16'h0001, 1'b1, 16'h0000);
        @(negedge clk);
        check("rst_ptr_zero_grant", 32'(bus.req_ready), 32'h4);
        wait_idle("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one 16-bit approximate adder (i_ap_adder) among NREQ requesters, e.g. RBM hidden/visible-unit accumulators.
- Round-robin arbitration, one registered result stage, valid/ready handshakes on both sides.
- A per-request exact-mode bit selects a full 16-bit exact add instead. This is used for calibration and golden comparison.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the response ID; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_a  in  16*NREQ  operand A; requester i occupies bits [16i+15:16i].
- req_b  in  16*NREQ  operand B, same packing as req_a.
- req_exact  in  NREQ  1 = exact add, 0 = approximate add.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  16  the sum.
- busy  out  1  rsp_valid, or any req_valid asserted.

Behaviour:
- Reset (asynchronous, rst_n low): rsp_valid=0, rsp_id=0, rsp_sum=0, RR pointer=0, req_ready=0.
  - Deassertion is synchronised by the upstream reset generator.
- Approximate sum for A,B:
  - SL = A[7:0]+B[7:0], 9 bits.
  - SH = A[15:4]+B[15:4]+A[0], 13 bits.
  - SUM = {SH[11:4], SL[7:0]}.
- Exact sum = (A+B) mod 2^16; carry-out is discarded.
- Output stage free condition: stage_free = !rsp_valid || rsp_ready.
- Arbitration (combinational, same cycle):
  - If stage_free and any req_valid, grant the first valid index at or after ptr, searching cyclically.
  - req_ready[g]=1 only for the granted index; all other bits are 0.
  - If the stage is not free, req_ready=0.
- Transfer on requester g at the clock edge where req_valid[g] && req_ready[g]:
  - rsp_sum <= selected sum of req_a[g], req_b[g].
  - rsp_id <= g, rsp_valid <= 1.
  - ptr <= (g+1) mod NREQ.
- Latency: request accepted in cycle N gives rsp_valid in cycle N+1.
- Throughput: one result per cycle while rsp_ready=1.
- Drain without a new grant (rsp_valid && rsp_ready, no grant that cycle): rsp_valid <= 0.
  - rsp_sum and rsp_id hold their last values; they are don't-care while rsp_valid=0.
- Back-pressure: while rsp_valid && !rsp_ready, rsp_sum and rsp_id are stable and all req_ready=0.
- Requester rules: a requester holds req_valid and its operands stable until accepted. Withdrawing before acceptance is illegal; an assertion in the bench flags it.
- ptr advances only on a grant; idle cycles leave it unchanged.
- Wrap-around: from g=NREQ-1, ptr goes to 0.
- Simultaneous drain and grant in the same cycle: the new result replaces the old one and rsp_valid stays 1 (back-to-back).
- Reset mid-operation: an in-flight result is discarded and no response is emitted after reset.
  - Requesters re-issue after reset; the bench checks no stale rsp_valid appears.
- Starvation bound: a requester holding req_valid is granted within NREQ grants.

Decomposition:
- Shared package (adder_share_pkg):
  - DATA_W=16.
  - APX_LO_W=8, APX_HI_LSB=4 (segment boundaries).
  - Function f_rr_pick(valid, ptr) returning the grant index and a found flag.
- Sub-modules:
  - i_ap_adder, instantiated once, fed by the grant mux.
  - Exact adder as an inline 16-bit add.
  - Result mux selected by req_exact[g].
  - Arbiter kept in-module; no extra sub-module.

Test Plan:
- Single request, approx, A=0x00F8, B=0x0008 on req 1 → accepted cycle 0; cycle 1 rsp_valid=1, rsp_id=1, rsp_sum=0x0000 (carry into bit 4 dropped).
  - Same operands with exact=1 → rsp_sum=0x0100.
- Noise path, A=0x00F1, B=0x0000, approx → rsp_sum=0x01F1; exact → 0x00F1.
- All 4 requesters valid continuously, rsp_ready=1, ptr=0 → grants in order 0,1,2,3,0.
  - One result per cycle; rsp_id sequence matches the grants.
- Back-pressure: rsp_ready=0 for 3 cycles after the first result → rsp_sum/rsp_id stable, req_ready=0.
  - Release → next grant in the same cycle as the drain, with no bubble.
- Wrap and idle: only req 3 valid, then only req 0 → grants 3 then 0.
  - An idle cycle between them leaves ptr unchanged.
- Assert rst_n=0 while rsp_valid=1 with rsp_ready=0 → rsp_valid=0 immediately (asynchronous).
  - After release, no response until a new request is accepted; exact A=0xFFFF, B=0x0001 then yields rsp_sum=0x0000.
